round_sequencer: RTL

- Game-flow controller that drives the round timer's inputs (gameState, roundTime, timer restart) and consumes its expiry pulse (cout).
- Judges each round as hit, miss or timeout, and maintains score and lives.
- Shortens roundTime as the player improves.
- Sits between the key-input/pattern logic and the timing block.

---
 rtl/game_pkg.sv | 17 +
 rtl/score_counter.sv | 20 ++
 rtl/round_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller and its display path.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int unsigned SCORE_W = 8;

  localparam logic [3:0] DEF_INIT_ROUND_TIME = 4'd9;
  localparam logic [3:0] DEF_MIN_ROUND_TIME  = 4'd2;
  localparam logic [1:0] DEF_LIVES           = 2'd3;

endpackage

// File: rtl/score_counter.sv
// Saturating hit counter with synchronous clear; holds at all-ones.
module score_counter
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] score
);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      score <= '0;
    end else if (inc && (score != {SCORE_W{1'b1}})) begin
      score <= score + 1'b1;
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Round flow controller: drives the round timer, judges hit/miss/timeout,
// tracks lives and speeds rounds up as the player keeps hitting.
module round_sequencer
  import game_pkg::*;
#(
  parameter logic [3:0] INIT_ROUND_TIME = DEF_INIT_ROUND_TIME,
  parameter logic [3:0] MIN_ROUND_TIME  = DEF_MIN_ROUND_TIME,
  parameter logic [1:0] LIVES           = DEF_LIVES,
  parameter logic [3:0] SPEEDUP_EVERY   = 4'd4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               hit,
  input  logic               miss,
  input  logic               cout,
  output logic               gameState,
  output logic [3:0]         roundTime,
  output logic               timerReset,
  output logic               newTarget,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               gameOver
);

  state_t     state;
  logic [3:0] hitCount;
  logic       lose_life;
  logic       score_inc;
  logic       score_clr;

  // A miss outranks a hit; a hit outranks a simultaneous timeout.
  always_comb begin
    lose_life = (state == PLAY) && (miss || (cout && !hit));
    score_inc = (state == PLAY) && hit && !miss;
    score_clr = (state == OVER) && start;
  end

  score_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .score (score)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      gameState  <= 1'b0;
      timerReset <= 1'b0;
      newTarget  <= 1'b0;
      gameOver   <= 1'b0;
      hitCount   <= 4'd0;
      lives      <= LIVES;
      roundTime  <= INIT_ROUND_TIME;
    end else begin
      timerReset <= 1'b0;
      newTarget  <= 1'b0;
      case (state)
        IDLE: begin
          gameState <= 1'b0;
          if (start) begin
            state      <= LOAD;
            timerReset <= 1'b1;
            newTarget  <= 1'b1;
          end
        end
        LOAD: begin
          state     <= PLAY;
          gameState <= 1'b1;
        end
        PLAY: begin
          if (lose_life) begin
            lives <= lives - 2'd1;
            gameState <= 1'b0;
            if (lives == 2'd1) begin
              state    <= OVER;
              gameOver <= 1'b1;
            end else begin
              state      <= LOAD;
              timerReset <= 1'b1;
              newTarget  <= 1'b1;
            end
          end else if (hit) begin
            state      <= LOAD;
            gameState  <= 1'b0;
            timerReset <= 1'b1;
            newTarget  <= 1'b1;
            if (hitCount + 4'd1 == SPEEDUP_EVERY) begin
              hitCount <= 4'd0;
              if (roundTime > MIN_ROUND_TIME) roundTime <= roundTime - 4'd1;
              else                            roundTime <= MIN_ROUND_TIME;
            end else begin
              hitCount <= hitCount + 4'd1;
            end
          end
        end
        OVER: begin
          gameState <= 1'b0;
          if (start) begin
            state      <= LOAD;
            gameOver   <= 1'b0;
            timerReset <= 1'b1;
            newTarget  <= 1'b1;
            hitCount   <= 4'd0;
            lives      <= LIVES;
            roundTime  <= INIT_ROUND_TIME;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
